// File: rtl/mem_port_arbiter_if.sv
// Bundle of client request/response and memory port signals for mem_port_arbiter.
// slave: the arbiter's view. master: the clients plus memory, as seen from outside.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_rwn;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_start;
  logic        mem_rwn;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_ready;
  logic        busy;
  logic        grant;

  modport slave (
    input  i_req, i_addr, d_req, d_rwn, d_addr, d_wdata, mem_data_out, mem_ready,
    output i_rdata, i_ack, d_rdata, d_ack, mem_start, mem_rwn, mem_address,
           mem_data_in, busy, grant
  );

  modport master (
    output i_req, i_addr, d_req, d_rwn, d_addr, d_wdata, mem_data_out, mem_ready,
    input  i_rdata, i_ack, d_rdata, d_ack, mem_start, mem_rwn, mem_address,
           mem_data_in, busy, grant
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-client (instruction fetch / load-store) front end for the single-port
// byte-addressed memory. One transaction at a time: IDLE -> ISSUE -> WAIT -> DONE.
// Optional macro ARB_RR_EN: round-robin tie breaking instead of data-over-instruction.
module mem_port_arbiter #(
  parameter int TIMEOUT_W = 8
) (
  input logic              clk,
  input logic              reset,   // synchronous, active low
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic                   grant_q, grant_d;     // 0 = instruction, 1 = data
  logic                   rwn_q, rwn_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            i_rdata_q, i_rdata_d;
  logic [31:0]            d_rdata_q, d_rdata_d;
  logic [TIMEOUT_W-1:0]   wait_cnt_q, wait_cnt_d;  // observes WAIT length only, never acts
  logic                   pick_data;

  // Arbitration: decide whether the data client wins this IDLE cycle.
  always_comb begin
`ifdef ARB_RR_EN
    // On a tie the client that was not granted last time wins.
    pick_data = bus.d_req & (~bus.i_req | ~grant_q);
`else
    pick_data = bus.d_req;
`endif
  end

  // Next-state logic and request latching.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rwn_d      = rwn_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        // mem_ready low here means an access aborted by reset is still draining.
        if ((bus.i_req || bus.d_req) && bus.mem_ready) begin
          state_d = ISSUE;
          grant_d = pick_data;
          if (pick_data) begin
            rwn_d   = bus.d_rwn;
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
          end else begin
            rwn_d   = 1'b1;
            addr_d  = bus.i_addr;
            wdata_d = 32'd0;
          end
        end
      end
      ISSUE: begin
        state_d    = WAIT;
        wait_cnt_d = '0;
      end
      WAIT: begin
        if (bus.mem_ready) begin
          state_d = DONE;
          if (rwn_q) begin
            if (grant_q) d_rdata_d = bus.mem_data_out;
            else         i_rdata_d = bus.mem_data_out;
          end
        end else if (wait_cnt_q != {TIMEOUT_W{1'b1}}) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      rwn_q      <= 1'b1;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      i_rdata_q  <= 32'd0;
      d_rdata_q  <= 32'd0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rwn_q      <= rwn_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Outputs are registers or decodes of the state register only.
  assign bus.mem_start   = (state_q == ISSUE);
  assign bus.mem_rwn     = rwn_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_data_in = wdata_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.grant       = grant_q;
  assign bus.i_ack       = (state_q == DONE) && !grant_q;
  assign bus.d_ack       = (state_q == DONE) && grant_q;
  assign bus.i_rdata     = i_rdata_q;
  assign bus.d_rdata     = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory model:
// start sampled while ready -> ready low for addr[1:0]+1 cycles, then ready high.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic hold_ready = 1'b0;
  int   checks = 0;
  int   failures = 0;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.TIMEOUT_W(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic         model_ready = 1'b1;
  logic [31:0]  model_data  = 32'd0;
  logic [1:0]   model_cnt   = 2'd0;
  logic [7:0]   model_addr  = 8'd0;
  logic [255:0] wr_valid    = '0;
  logic [31:0]  wr_img [256];

  function automatic logic [31:0] image_word(input logic [7:0] a);
    case (a)
      8'd0:    return 32'h010015C4;
      8'd3:    return 32'h03366001;
      8'd64:   return 32'h00000014;
      default: return 32'h00000000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.mem_start && model_ready) begin
      model_ready <= 1'b0;
      model_cnt   <= bus.mem_address[1:0];
      model_addr  <= bus.mem_address[7:0];
      if (!bus.mem_rwn) begin
        wr_img[bus.mem_address[7:0]]   <= bus.mem_data_in;
        wr_valid[bus.mem_address[7:0]] <= 1'b1;
      end
    end else if (!model_ready) begin
      if (model_cnt == 2'd0) begin
        model_ready <= 1'b1;
        model_data  <= wr_valid[model_addr] ? wr_img[model_addr] : image_word(model_addr);
      end else begin
        model_cnt <= model_cnt - 2'd1;
      end
    end
  end

  assign bus.mem_ready    = model_ready & ~hold_ready;
  assign bus.mem_data_out = model_data;

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the wanted ack appears (bounded); lat=-1 on timeout.
  task automatic wait_for_ack(input bit want_d, output int lat, output int n_start,
                              output int n_other, output logic start_rwn,
                              output logic [31:0] start_addr, output logic [31:0] start_din);
    lat = -1; n_start = 0; n_other = 0;
    start_rwn = 1'b0; start_addr = 32'd0; start_din = 32'd0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (bus.mem_start) begin
        n_start++;
        start_rwn  = bus.mem_rwn;
        start_addr = bus.mem_address;
        start_din  = bus.mem_data_in;
      end
      if (want_d ? bus.i_ack : bus.d_ack) n_other++;
      if (want_d ? bus.d_ack : bus.i_ack) begin
        lat = n;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_rwn = 1;
    bus.d_addr = 0; bus.d_wdata = 0;
    reset = 0;
    tick();
    tick();
    checks++;
    if (bus.i_rdata !== 32'd0 || bus.d_rdata !== 32'd0) begin
      failures++; $display("FAIL reset_rdata: got i=%h d=%h expected 0", bus.i_rdata, bus.d_rdata);
    end
    checks++;
    if (bus.i_ack !== 1'b0 || bus.d_ack !== 1'b0 || bus.busy !== 1'b0 || bus.grant !== 1'b0) begin
      failures++; $display("FAIL reset_ctrl: got i_ack=%b d_ack=%b busy=%b grant=%b expected 0",
                           bus.i_ack, bus.d_ack, bus.busy, bus.grant);
    end
    checks++;
    if (bus.mem_start !== 1'b0 || bus.mem_rwn !== 1'b1 || bus.mem_address !== 32'd0 ||
        bus.mem_data_in !== 32'd0) begin
      failures++; $display("FAIL reset_mem: got start=%b rwn=%b addr=%h din=%h expected 0/1/0/0",
                           bus.mem_start, bus.mem_rwn, bus.mem_address, bus.mem_data_in);
    end
    reset = 1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_instr_read();
    int lat, ns, no; logic srwn; logic [31:0] sa, sd;
    bus.i_addr = 32'd0; bus.i_req = 1;
    wait_for_ack(1'b0, lat, ns, no, srwn, sa, sd);
    bus.i_req = 0;
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL instr_latency: got %0d expected 4", lat); end
    checks++;
    if (bus.i_rdata !== 32'h010015C4) begin
      failures++; $display("FAIL instr_rdata: got %h expected 010015c4", bus.i_rdata);
    end
    checks++;
    if (no !== 0 || ns !== 1 || srwn !== 1'b1 || bus.grant !== 1'b0) begin
      failures++; $display("FAIL instr_ctrl: got d_acks=%0d starts=%0d rwn=%b grant=%b expected 0/1/1/0",
                           no, ns, srwn, bus.grant);
    end
    tick();
    checks++;
    if (bus.i_ack !== 1'b0 || bus.busy !== 1'b0 || bus.i_rdata !== 32'h010015C4) begin
      failures++; $display("FAIL instr_after: got ack=%b busy=%b rdata=%h expected 0/0/010015c4",
                           bus.i_ack, bus.busy, bus.i_rdata);
    end
    $display("test_instr_read lat=%0d rdata=%h", lat, bus.i_rdata);
  endtask

  task automatic test_data_read();
    int lat, ns, no; logic srwn; logic [31:0] sa, sd;
    bus.d_rwn = 1; bus.d_addr = 32'd3; bus.d_req = 1;
    wait_for_ack(1'b1, lat, ns, no, srwn, sa, sd);
    bus.d_req = 0;
    checks++;
    if (lat !== 7) begin failures++; $display("FAIL data_latency: got %0d expected 7", lat); end
    checks++;
    if (bus.d_rdata !== 32'h03366001) begin
      failures++; $display("FAIL data_rdata: got %h expected 03366001", bus.d_rdata);
    end
    checks++;
    if (sa !== 32'd3 || bus.grant !== 1'b1 || no !== 0) begin
      failures++; $display("FAIL data_ctrl: got addr=%h grant=%b i_acks=%0d expected 3/1/0",
                           sa, bus.grant, no);
    end
    tick();
    $display("test_data_read lat=%0d rdata=%h", lat, bus.d_rdata);
  endtask

  task automatic test_write_read();
    int lat, ns, no; logic srwn; logic [31:0] sa, sd;
    bus.d_rwn = 0; bus.d_addr = 32'd200; bus.d_wdata = 32'hDEADBEEF; bus.d_req = 1;
    wait_for_ack(1'b1, lat, ns, no, srwn, sa, sd);
    bus.d_req = 0;
    checks++;
    if (lat !== 4 || srwn !== 1'b0 || sd !== 32'hDEADBEEF || sa !== 32'd200) begin
      failures++; $display("FAIL write_issue: got lat=%0d rwn=%b din=%h addr=%h expected 4/0/deadbeef/c8",
                           lat, srwn, sd, sa);
    end
    checks++;
    if (bus.d_rdata !== 32'h03366001) begin
      failures++; $display("FAIL write_rdata_held: got %h expected 03366001", bus.d_rdata);
    end
    $display("test_write lat=%0d", lat);
    tick();
    bus.d_rwn = 1; bus.d_wdata = 32'h0; bus.d_req = 1;
    wait_for_ack(1'b1, lat, ns, no, srwn, sa, sd);
    bus.d_req = 0;
    checks++;
    if (lat !== 4 || bus.d_rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL readback: got lat=%0d rdata=%h expected 4/deadbeef", lat, bus.d_rdata);
    end
    $display("test_readback lat=%0d rdata=%h", lat, bus.d_rdata);
    tick();
    // Instruction fetch right after a write must drive mem_data_in to zero.
    bus.i_addr = 32'd200; bus.i_req = 1;
    wait_for_ack(1'b0, lat, ns, no, srwn, sa, sd);
    bus.i_req = 0;
    checks++;
    if (sd !== 32'd0 || srwn !== 1'b1 || bus.i_rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL instr_after_write: got din=%h rwn=%b rdata=%h expected 0/1/deadbeef",
                           sd, srwn, bus.i_rdata);
    end
    $display("test_instr_after_write rdata=%h", bus.i_rdata);
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, ns, no; logic srwn; logic [31:0] sa, sd;
    bus.i_addr = 32'd0; bus.d_addr = 32'd64; bus.d_rwn = 1;
    bus.i_req = 1; bus.d_req = 1;
`ifdef ARB_RR_EN
    for (int t = 0; t < 4; t++) begin
      wait_for_ack((t % 2) == 0, lat, ns, no, srwn, sa, sd);
      checks++;
      if (lat !== ((t == 0) ? 4 : 5) || no !== 0) begin
        failures++; $display("FAIL rr_order_%0d: got lat=%0d other_acks=%0d expected %0d/0",
                             t, lat, no, (t == 0) ? 4 : 5);
      end
      $display("test_rr txn=%0d lat=%0d grant=%b", t, lat, bus.grant);
    end
    checks++;
    if (bus.d_rdata !== 32'h00000014 || bus.i_rdata !== 32'h010015C4) begin
      failures++; $display("FAIL rr_rdata: got d=%h i=%h expected 00000014/010015c4",
                           bus.d_rdata, bus.i_rdata);
    end
    bus.i_req = 0; bus.d_req = 0;
`else
    wait_for_ack(1'b1, lat, ns, no, srwn, sa, sd);
    bus.d_req = 0;
    checks++;
    if (lat !== 4 || no !== 0 || bus.d_rdata !== 32'h00000014) begin
      failures++; $display("FAIL tie_data_first: got lat=%0d i_acks=%0d rdata=%h expected 4/0/00000014",
                           lat, no, bus.d_rdata);
    end
    $display("test_tie data lat=%0d rdata=%h", lat, bus.d_rdata);
    wait_for_ack(1'b0, lat, ns, no, srwn, sa, sd);
    bus.i_req = 0;
    checks++;
    if (lat !== 5 || no !== 0 || bus.i_rdata !== 32'h010015C4) begin
      failures++; $display("FAIL tie_instr_second: got lat=%0d d_acks=%0d rdata=%h expected 5/0/010015c4",
                           lat, no, bus.i_rdata);
    end
    $display("test_tie instr lat=%0d rdata=%h", lat, bus.i_rdata);
`endif
    tick();
  endtask

  task automatic test_reset_in_wait();
    int lat, ns, no, n_start; logic srwn; logic [31:0] sa, sd;
    bus.i_addr = 32'd3; bus.i_req = 1;
    tick();                      // ISSUE
    tick();                      // WAIT
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL rst_wait_busy: got %b expected 1", bus.busy); end
    reset = 0;
    tick();
    reset = 1;
    checks++;
    if (bus.busy !== 1'b0 || bus.i_ack !== 1'b0 || bus.i_rdata !== 32'd0 || bus.mem_start !== 1'b0) begin
      failures++; $display("FAIL rst_wait_state: got busy=%b ack=%b rdata=%h start=%b expected 0/0/0/0",
                           bus.busy, bus.i_ack, bus.i_rdata, bus.mem_start);
    end
    n_start = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (bus.i_ack || bus.d_ack) begin
        failures++; checks++; $display("FAIL rst_wait_spurious_ack: got ack at step %0d expected none", n);
      end
      if (bus.mem_start) begin n_start = n; break; end
    end
    checks++;
    if (n_start !== 4) begin failures++; $display("FAIL rst_wait_drain: got start at %0d expected 4", n_start); end
    wait_for_ack(1'b0, lat, ns, no, srwn, sa, sd);
    bus.i_req = 0;
    checks++;
    if (lat !== 6 || bus.i_rdata !== 32'h03366001) begin
      failures++; $display("FAIL rst_wait_complete: got lat=%0d rdata=%h expected 6/03366001", lat, bus.i_rdata);
    end
    $display("test_reset_in_wait start_step=%0d lat=%0d rdata=%h", n_start, lat, bus.i_rdata);
    tick();
  endtask

  task automatic test_ready_hold();
    int lat, ns, no; logic srwn; logic [31:0] sa, sd;
    hold_ready = 1;
    bus.d_rwn = 1; bus.d_addr = 32'd64; bus.d_req = 1;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if (bus.mem_start !== 1'b0 || bus.busy !== 1'b0) begin
        failures++; $display("FAIL hold_idle_%0d: got start=%b busy=%b expected 0/0", n, bus.mem_start, bus.busy);
      end
    end
    hold_ready = 0;
    tick();
    checks++;
    if (bus.mem_start !== 1'b1) begin failures++; $display("FAIL hold_release: got start=%b expected 1", bus.mem_start); end
    wait_for_ack(1'b1, lat, ns, no, srwn, sa, sd);
    bus.d_req = 0;
    checks++;
    if (lat !== 3 || bus.d_rdata !== 32'h00000014) begin
      failures++; $display("FAIL hold_complete: got lat=%0d rdata=%h expected 3/00000014", lat, bus.d_rdata);
    end
    $display("test_ready_hold lat=%0d rdata=%h", lat, bus.d_rdata);
    tick();
  endtask

  initial begin
    test_reset();
    test_instr_read();
    test_data_read();
    test_write_read();
    test_back_to_back();
    test_reset_in_wait();
    test_ready_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
